multiword_add_seq: RTL

// Multi-cycle wide adder built around one RCA16 instance. It latches two wide

---
 rtl/multiword_add_seq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/multiword_add_seq.sv
// Sequential wide adder: one RCA16 adds one 16-bit slice per clock, LSB first; done pulses WORDS+1 cycles after start.
// Backpressure: start is ignored while busy; it is accepted in IDLE or in the done cycle. Optional ovf port: MULTIWORD_ADD_OVF_EN.

module rca16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);
  logic [16:0] c;

  assign c[0] = ci;
  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[16];
endmodule

module multiword_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [16*WORDS-1:0]   A,
  input  logic [16*WORDS-1:0]   B,
  input  logic                  Cin,
  output logic                  busy,
  output logic                  done,
  output logic [16*WORDS-1:0]   Sum,
  output logic                  Cout
`ifdef MULTIWORD_ADD_OVF_EN
  ,
  output logic                  ovf
`endif
);
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                    state_q, state_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [IDXW-1:0]           idx_q, idx_d;
  logic                      carry_q, carry_d;
  logic [WORDS-1:0][15:0]    a_q, a_d;
  logic [WORDS-1:0][15:0]    b_q, b_d;
  logic [WORDS-1:0][15:0]    sum_q, sum_d;
  logic                      cout_q, cout_d;
  logic                      ovf_q, ovf_d;

  logic [15:0] rca_s;
  logic        rca_co;

  rca16 u_rca16 (
    .a  (a_q[idx_q]),
    .b  (b_q[idx_q]),
    .ci (carry_q),
    .s  (rca_s),
    .co (rca_co)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          idx_d   = '0;
          state_d = BUSY;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        sum_d[idx_q] = rca_s;
        carry_d      = rca_co;
        busy_d       = 1'b1;
        idx_d        = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // Overflow uses the top bit of the slice being written now, not sum_q.
          cout_d  = rca_co;
          ovf_d   = (a_q[WORDS-1][15] == b_q[WORDS-1][15]) &&
                    (rca_s[15] != a_q[WORDS-1][15]);
          idx_d   = '0;
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;
`ifdef MULTIWORD_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
